mem_port_arbiter: RTL and testbench

Arbiter that shares one single-port unified memory between the instruction-fetch port and the data-access port of the RV32I core. It replaces the separate IMem/DMem paths when the core is built against a single memory. One access is outstanding at a time. Data accesses have priority, with a starvation guard for fetch and a watchdog timeout. Pipeline stalls are derived directly from the per-port `*_done` strobes.

---
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports, data-first with fetch starvation guard and watchdog
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err,
    output logic              busy,
    output logic              owner_d
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q;
    logic [SW-1:0]     streak_q;
    logic [TW-1:0]     wait_q;
    logic              owner_q;
    logic              req_q;
    logic              we_q;
    logic [2:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              timeout_hit;
    logic              done;
    logic              gnt_d;

    // Watchdog expiry, completion strobe and the data-wins-unless-starving grant decision
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (wait_q == TW'(TIMEOUT - 1)) && !mem_ack;
        done        = (state_q == BUSY) && (mem_ack || timeout_hit);
        gnt_d       = dm_req && !(if_req && streak_q == SW'(STARVE_LIMIT));
    end

    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign if_done   = done && !owner_q;
    assign dm_done   = done && owner_q;
    assign bus_err   = done && timeout_hit;
    assign busy      = (state_q == BUSY);
    assign owner_d   = owner_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Arbiter FSM: grant from IDLE, wait in BUSY for ack or watchdog, always return through IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
            wait_q   <= '0;
            owner_q  <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (state_q == IDLE) begin
            if (dm_req || if_req) begin
                state_q  <= BUSY;
                req_q    <= 1'b1;
                owner_q  <= gnt_d;
                wait_q   <= '0;
                we_q     <= gnt_d ? dm_we : 1'b0;
                size_q   <= gnt_d ? dm_size : 3'b010;
                addr_q   <= gnt_d ? dm_addr : if_addr;
                wdata_q  <= gnt_d ? dm_wdata : '0;
                streak_q <= !(gnt_d && if_req) ? '0 :
                            (streak_q == SW'(STARVE_LIMIT)) ? streak_q : streak_q + 1'b1;
            end
        end else if (done) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
        end else begin
            wait_q <= wait_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios for the unified-memory port arbiter
module tb_mem_port_arbiter;
    logic        clk, rst;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [2:0]  dm_size;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_done, dm_done, mem_req, mem_we, bus_err, busy, owner_d;
    logic [2:0]  mem_size;
    int          vec = 0;
    int          bad = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_err(bus_err), .busy(busy), .owner_d(owner_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start a new cycle: inputs are driven 2 time units after the edge, outputs checked 1 later
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0; dm_size = 0;
        step(); step();
        #1;
        vec++; if ({mem_req, mem_we, busy, owner_d} !== 4'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 0000", {mem_req, mem_we, busy, owner_d}); end
        vec++; if ({mem_addr, mem_wdata, mem_size} !== 67'b0) begin bad++; $display("FAIL reset_bus: addr %h wdata %h size %b want 0", mem_addr, mem_wdata, mem_size); end
        vec++; if ({if_done, dm_done, bus_err} !== 3'b0) begin bad++; $display("FAIL reset_done: got %b want 000", {if_done, dm_done, bus_err}); end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        step();
        if_req = 1; if_addr = 32'h100;
        #1;
        vec++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_idle: mem_req %b want 0", mem_req); end
        step(); #1;
        vec++; if ({mem_req, busy, owner_d, mem_we} !== 4'b1100) begin bad++; $display("FAIL fetch_grant: req/busy/own/we %b want 1100", {mem_req, busy, owner_d, mem_we}); end
        vec++; if (mem_addr !== 32'h100 || mem_size !== 3'b010 || mem_wdata !== 32'h0) begin bad++; $display("FAIL fetch_bus: addr %h size %b wdata %h want 100 010 0", mem_addr, mem_size, mem_wdata); end
        vec++; if (if_done !== 1'b0) begin bad++; $display("FAIL fetch_early1: if_done %b want 0", if_done); end
        step(); #1;
        vec++; if (if_done !== 1'b0) begin bad++; $display("FAIL fetch_early2: if_done %b want 0", if_done); end
        step();
        mem_ack = 1; mem_rdata = 32'h00500093;
        #1;
        vec++; if ({if_done, dm_done, bus_err} !== 3'b100) begin bad++; $display("FAIL fetch_done: i/d/err %b want 100", {if_done, dm_done, bus_err}); end
        vec++; if (if_rdata !== 32'h00500093) begin bad++; $display("FAIL fetch_rdata: got %h want 00500093", if_rdata); end
        if_req = 0;
        step();
        mem_ack = 0;
        #1;
        vec++; if ({busy, mem_req, if_done} !== 3'b000) begin bad++; $display("FAIL fetch_end: busy/req/done %b want 000", {busy, mem_req, if_done}); end
    endtask

    task automatic test_contention();
        step();
        if_req = 1; if_addr = 32'h300;
        dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_size = 3'b000;
        step(); #1;
        vec++; if ({mem_req, owner_d, mem_we} !== 3'b111) begin bad++; $display("FAIL cont_dgrant: req/own/we %b want 111", {mem_req, owner_d, mem_we}); end
        vec++; if (mem_addr !== 32'h2000 || mem_wdata !== 32'hDEADBEEF || mem_size !== 3'b000) begin bad++; $display("FAIL cont_dbus: addr %h wdata %h size %b", mem_addr, mem_wdata, mem_size); end
        mem_ack = 1;
        #1;
        vec++; if ({dm_done, if_done} !== 2'b10) begin bad++; $display("FAIL cont_ddone: d/i %b want 10", {dm_done, if_done}); end
        dm_req = 0; dm_we = 0;
        step();
        mem_ack = 0;
        #1;
        vec++; if ({mem_req, busy} !== 2'b00) begin bad++; $display("FAIL cont_gap: req/busy %b want 00", {mem_req, busy}); end
        step(); #1;
        vec++; if ({mem_req, owner_d, mem_we} !== 3'b100 || mem_addr !== 32'h300 || mem_wdata !== 32'h0 || mem_size !== 3'b010) begin bad++; $display("FAIL cont_igrant: ctl %b addr %h wdata %h size %b", {mem_req, owner_d, mem_we}, mem_addr, mem_wdata, mem_size); end
        mem_ack = 1;
        #1;
        vec++; if ({if_done, dm_done} !== 2'b10) begin bad++; $display("FAIL cont_idone: i/d %b want 10", {if_done, dm_done}); end
        if_req = 0;
        step();
        mem_ack = 0;
    endtask

    task automatic test_starvation();
        logic [9:0] seq;
        logic [9:0] want;
        want = 10'b1111011110;
        step();
        if_req = 1; if_addr = 32'h400; dm_req = 1; dm_we = 0; dm_addr = 32'h80; dm_size = 3'b010;
        for (int g = 0; g < 10; g++) begin
            step(); #1;
            seq[9 - g] = owner_d;
            vec++; if (mem_req !== 1'b1) begin bad++; $display("FAIL starve_req%0d: mem_req %b want 1", g, mem_req); end
            mem_ack = 1;
            step();
            mem_ack = 0;
        end
        if_req = 0; dm_req = 0;
        vec++; if (seq !== want) begin bad++; $display("FAIL starve_seq: owners %b want %b (1=D)", seq, want); end
        step();
    endtask

    task automatic test_timeout(input logic ack_last);
        step();
        dm_req = 1; dm_we = 0; dm_addr = 32'h40; dm_size = 3'b010;
        for (int k = 1; k < 16; k++) begin
            step(); #1;
            vec++; if ({mem_req, dm_done, bus_err} !== 3'b100) begin bad++; $display("FAIL tmo_wait%0d: req/done/err %b want 100", k, {mem_req, dm_done, bus_err}); end
        end
        step();
        mem_ack = ack_last;
        #1;
        vec++; if ({dm_done, bus_err} !== {1'b1, ~ack_last}) begin bad++; $display("FAIL tmo_hit(ack=%b): done/err %b want 1%b", ack_last, {dm_done, bus_err}, ~ack_last); end
        dm_req = 0;
        step();
        mem_ack = 0;
        #1;
        vec++; if ({mem_req, busy, bus_err} !== 3'b000) begin bad++; $display("FAIL tmo_end(ack=%b): req/busy/err %b want 000", ack_last, {mem_req, busy, bus_err}); end
    endtask

    task automatic test_async_reset();
        step();
        if_req = 1; if_addr = 32'h500; dm_req = 1; dm_we = 1; dm_addr = 32'h600; dm_wdata = 32'h1; dm_size = 3'b010;
        step(); #1;
        vec++; if ({mem_req, owner_d} !== 2'b11) begin bad++; $display("FAIL arst_pre: req/own %b want 11", {mem_req, owner_d}); end
        #1 rst = 1;
        #1;
        vec++; if ({mem_req, busy, owner_d} !== 3'b000) begin bad++; $display("FAIL arst_now: req/busy/own %b want 000", {mem_req, busy, owner_d}); end
        vec++; if ({if_done, dm_done} !== 2'b00) begin bad++; $display("FAIL arst_done: i/d %b want 00", {if_done, dm_done}); end
        #1 rst = 0; dm_req = 0; dm_we = 0;
        step(); #1;
        vec++; if ({mem_req, owner_d} !== 2'b10 || mem_addr !== 32'h500) begin bad++; $display("FAIL arst_regrant: req/own %b addr %h want 10 500", {mem_req, owner_d}, mem_addr); end
        mem_ack = 1;
        if_req = 0;
        step();
        mem_ack = 0;
    endtask

    task automatic test_back_to_back();
        step();
        if_req = 1; if_addr = 32'h100;
        step(); #1;
        vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin bad++; $display("FAIL b2b_first: req %b addr %h want 1 100", mem_req, mem_addr); end
        mem_ack = 1;
        #1;
        vec++; if (if_done !== 1'b1) begin bad++; $display("FAIL b2b_done1: if_done %b want 1", if_done); end
        if_addr = 32'h104;
        step();
        mem_ack = 0;
        #1;
        vec++; if ({mem_req, if_done} !== 2'b00) begin bad++; $display("FAIL b2b_gap: req/done %b want 00", {mem_req, if_done}); end
        step(); #1;
        vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin bad++; $display("FAIL b2b_second: req %b addr %h want 1 104", mem_req, mem_addr); end
        mem_ack = 1;
        #1;
        vec++; if (if_done !== 1'b1) begin bad++; $display("FAIL b2b_done2: if_done %b want 1", if_done); end
        if_req = 0;
        step();
        mem_ack = 0;
        #1;
        vec++; if ({mem_req, busy} !== 2'b00) begin bad++; $display("FAIL b2b_nodup: req/busy %b want 00", {mem_req, busy}); end
        step();
        mem_ack = 1;
        #1;
        vec++; if ({if_done, dm_done, bus_err} !== 3'b000) begin bad++; $display("FAIL stray_ack: i/d/err %b want 000", {if_done, dm_done, bus_err}); end
        step();
        mem_ack = 0;
        #1;
        vec++; if ({mem_req, busy} !== 2'b00) begin bad++; $display("FAIL stray_idle: req/busy %b want 00", {mem_req, busy}); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
